// File: rtl/length_pack_controller_pkg.sv
// Shared definitions for the length/pack controller: word pattern codes,
// the code-to-length rule and the port width helpers.
package length_pack_controller_pkg;

  typedef enum logic [2:0] {
    CODE_ZZZZ = 3'd0,
    CODE_XXXX = 3'd1,
    CODE_MMMM = 3'd2,
    CODE_MMXX = 3'd3,
    CODE_ZZZX = 3'd4,
    CODE_MMMX = 3'd5
  } code_e;

  // Illegal codes are costed like a raw word so the packer never under-allocates.
  function automatic int code_len(input logic [2:0] code, input int word_bits, input int idx_w);
    int len;
    case (code)
      CODE_ZZZZ: len = 2;
      CODE_XXXX: len = 2 + word_bits;
      CODE_MMMM: len = 2 + idx_w;
      CODE_MMXX: len = 4 + idx_w + word_bits / 2;
      CODE_ZZZX: len = 4 + word_bits / 4;
      CODE_MMMX: len = 4 + idx_w + word_bits / 4;
      default:   len = 2 + word_bits;
    endcase
    return len;
  endfunction

  function automatic logic code_illegal(input logic [2:0] code);
    return (code > 3'd5);
  endfunction

  function automatic int len_width(input int word_bits);
    return $clog2(word_bits + 3);
  endfunction

  function automatic int fill_width(input int cache_line);
    return $clog2(cache_line + 1);
  endfunction

  function automatic int block_width(input int words_per_block, input int word_bits);
    return $clog2(words_per_block * (word_bits + 2) + 1);
  endfunction

endpackage

// File: rtl/length_pack_controller_word_length_decoder.sv
// Combinational decoder from one lane's pattern code to its compressed length.
module word_length_decoder
  import length_pack_controller_pkg::*;
#(
  parameter int WORD_BITS = 32,
  parameter int IDX_W     = 4,
  parameter int LW        = len_width(WORD_BITS)
) (
  input  logic [2:0]    i_code,
  output logic [LW-1:0] o_len,
  output logic          o_illegal
);

  // Length lookup and illegal-code detection
  always_comb begin
    o_len     = LW'(code_len(i_code, WORD_BITS, IDX_W));
    o_illegal = code_illegal(i_code);
  end

endmodule

// File: rtl/length_pack_controller.sv
// N-lane length generator: per-lane lengths and offsets, output-line fill
// tracking with store/flush control, and per-block send-back decision.
module length_pack_controller
  import length_pack_controller_pkg::*;
#(
  parameter int LANES           = 2,
  parameter int WORD_BITS       = 32,
  parameter int IDX_W           = 4,
  parameter int CACHE_LINE      = 128,
  parameter int WORDS_PER_BLOCK = 16,
  localparam int LW = len_width(WORD_BITS),
  localparam int FW = fill_width(CACHE_LINE),
  localparam int BW = block_width(WORDS_PER_BLOCK, WORD_BITS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [3*LANES-1:0]  i_code,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [LW*LANES-1:0] o_lane_len,
  output logic [FW*LANES-1:0] o_lane_off,
  output logic [FW-1:0]       o_shift_amount,
  output logic                o_store_flag,
  output logic                o_flush,
  output logic                o_send_back,
  output logic [BW-1:0]       o_block_bits,
  output logic                o_err
);

  // One extra bit holds fill+T, which can exceed CACHE_LINE before the overflow test.
  localparam int SW = FW + 1;
  localparam logic [SW-1:0] LINE_LIM  = SW'(CACHE_LINE);
  localparam logic [BW-1:0] BLOCK_LIM = BW'(WORDS_PER_BLOCK * WORD_BITS);

  logic [LW-1:0]    lane_len_s [LANES];
  logic [LANES-1:0] lane_illegal_s;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      word_length_decoder #(
        .WORD_BITS (WORD_BITS),
        .IDX_W     (IDX_W),
        .LW        (LW)
      ) u_dec (
        .i_code    (i_code[3*k +: 3]),
        .o_len     (lane_len_s[k]),
        .o_illegal (lane_illegal_s[k])
      );
    end
  endgenerate

  logic                valid_q, valid_d;
  logic [LW*LANES-1:0] lane_len_q, lane_len_d;
  logic [FW*LANES-1:0] lane_off_q, lane_off_d;
  logic [FW-1:0]       shift_q, shift_d;
  logic                store_q, store_d;
  logic                flush_q, flush_d;
  logic                send_back_q, send_back_d;
  logic [BW-1:0]       block_bits_q, block_bits_d;
  logic                err_q, err_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [BW-1:0]       block_q, block_d;

  logic                accept_s;
  logic [SW-1:0]       total_s, sum_s, new_fill_s, run_s;
  logic [FW-1:0]       shift_s;
  logic                store_s, flush_s, send_back_s;
  logic [BW-1:0]       block_sum_s;
  logic [LW*LANES-1:0] len_pack_s;
  logic [FW*LANES-1:0] off_pack_s;

  assign o_ready  = i_reset && (!valid_q || i_ready);
  assign accept_s = i_valid && o_ready;

  // Beat total, line placement, prefix-sum offsets and block accounting
  always_comb begin
    total_s    = '0;
    len_pack_s = '0;
    for (int k = 0; k < LANES; k++) begin
      total_s                  = total_s + SW'(lane_len_s[k]);
      len_pack_s[LW*k +: LW]   = lane_len_s[k];
    end
    sum_s = SW'(fill_q) + total_s;
    if (sum_s > LINE_LIM) begin
      store_s    = 1'b1;
      shift_s    = '0;
      new_fill_s = total_s;
    end else begin
      store_s    = 1'b0;
      shift_s    = fill_q;
      new_fill_s = sum_s;
    end
    flush_s    = (new_fill_s == LINE_LIM) || i_last;
    run_s      = SW'(shift_s);
    off_pack_s = '0;
    for (int k = 0; k < LANES; k++) begin
      off_pack_s[FW*k +: FW] = FW'(run_s);
      run_s                  = run_s + SW'(lane_len_s[k]);
    end
    block_sum_s = block_q + BW'(total_s);
    send_back_s = i_last && (block_sum_s > BLOCK_LIM);
  end

  // Next state: load on accept, drop valid on drain, otherwise hold
  always_comb begin
    valid_d      = valid_q;
    lane_len_d   = lane_len_q;
    lane_off_d   = lane_off_q;
    shift_d      = shift_q;
    store_d      = store_q;
    flush_d      = flush_q;
    send_back_d  = send_back_q;
    block_bits_d = block_bits_q;
    err_d        = err_q;
    fill_d       = fill_q;
    block_d      = block_q;
    if (accept_s) begin
      valid_d      = 1'b1;
      lane_len_d   = len_pack_s;
      lane_off_d   = off_pack_s;
      shift_d      = shift_s;
      store_d      = store_s;
      flush_d      = flush_s;
      send_back_d  = send_back_s;
      block_bits_d = block_sum_s;
      err_d        = err_q | (|lane_illegal_s);
      fill_d       = flush_s ? {FW{1'b0}} : FW'(new_fill_s);
      block_d      = i_last ? {BW{1'b0}} : block_sum_s;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      valid_q      <= 1'b0;
      lane_len_q   <= '0;
      lane_off_q   <= '0;
      shift_q      <= '0;
      store_q      <= 1'b0;
      flush_q      <= 1'b0;
      send_back_q  <= 1'b0;
      block_bits_q <= '0;
      err_q        <= 1'b0;
      fill_q       <= '0;
      block_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      lane_len_q   <= lane_len_d;
      lane_off_q   <= lane_off_d;
      shift_q      <= shift_d;
      store_q      <= store_d;
      flush_q      <= flush_d;
      send_back_q  <= send_back_d;
      block_bits_q <= block_bits_d;
      err_q        <= err_d;
      fill_q       <= fill_d;
      block_q      <= block_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_lane_len     = lane_len_q;
  assign o_lane_off     = lane_off_q;
  assign o_shift_amount = shift_q;
  assign o_store_flag   = store_q;
  assign o_flush        = flush_q;
  assign o_send_back    = send_back_q;
  assign o_block_bits   = block_bits_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_length_pack_controller.sv
// Self-checking bench for length_pack_controller at default parameters:
// directed vector table, hand sequences, and a randomized model comparison.
module tb_length_pack_controller;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_last, i_ready;
  logic [5:0]  i_code;
  logic        o_ready, o_valid, o_store_flag, o_flush, o_send_back, o_err;
  logic [11:0] o_lane_len;
  logic [15:0] o_lane_off;
  logic [7:0]  o_shift_amount;
  logic [9:0]  o_block_bits;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  length_pack_controller dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_code         (i_code),
    .i_last         (i_last),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_lane_len     (o_lane_len),
    .o_lane_off     (o_lane_off),
    .o_shift_amount (o_shift_amount),
    .o_store_flag   (o_store_flag),
    .o_flush        (o_flush),
    .o_send_back    (o_send_back),
    .o_block_bits   (o_block_bits),
    .o_err          (o_err)
  );

  typedef struct {
    logic [2:0] c0, c1;
    logic       last;
    int len0, len1, off0, off1, shift, store, flush, send, block, err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string tag, input string field, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got %0d expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk(tag, "valid", int'(o_valid), 1);
    chk(tag, "len0", int'(o_lane_len[5:0]), v.len0);
    chk(tag, "len1", int'(o_lane_len[11:6]), v.len1);
    chk(tag, "off0", int'(o_lane_off[7:0]), v.off0);
    chk(tag, "off1", int'(o_lane_off[15:8]), v.off1);
    chk(tag, "shift", int'(o_shift_amount), v.shift);
    chk(tag, "store", int'(o_store_flag), v.store);
    chk(tag, "flush", int'(o_flush), v.flush);
    chk(tag, "send_back", int'(o_send_back), v.send);
    chk(tag, "block_bits", int'(o_block_bits), v.block);
    chk(tag, "err", int'(o_err), v.err);
  endtask

  task automatic check_zero(input string tag);
    chk(tag, "valid", int'(o_valid), 0);
    chk(tag, "lens", int'(o_lane_len), 0);
    chk(tag, "offs", int'(o_lane_off), 0);
    chk(tag, "shift", int'(o_shift_amount), 0);
    chk(tag, "flags", int'({o_store_flag, o_flush, o_send_back, o_err}), 0);
    chk(tag, "block_bits", int'(o_block_bits), 0);
  endtask

  // Called just after a clock edge; leaves time just after the next edge.
  task automatic do_reset(input int cycles);
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_code  = 6'd0;
    repeat (cycles) @(posedge clk);
    #1;
    check_zero("in_reset");
    chk("in_reset", "ready", int'(o_ready), 0);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("after_reset");
    chk("after_reset", "ready", int'(o_ready), 1);
  endtask

  task automatic beat(input string tag, input logic [2:0] c0, input logic [2:0] c1, input logic last);
    i_valid = 1'b1;
    i_code  = {c1, c0};
    i_last  = last;
    #1;
    chk(tag, "ready", int'(o_ready), 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  function automatic int mlen(input int c);
    case (c)
      0: return 2;
      1: return 34;
      2: return 6;
      3: return 24;
      4: return 12;
      5: return 16;
      default: return 34;
    endcase
  endfunction

  function automatic vec_t mk(input int c0, input int c1, input int last,
                              input int l0, input int l1, input int f0, input int f1,
                              input int sh, input int st, input int fl, input int sb,
                              input int bb, input int er);
    vec_t v;
    v.c0 = 3'(c0); v.c1 = 3'(c1); v.last = 1'(last);
    v.len0 = l0; v.len1 = l1; v.off0 = f0; v.off1 = f1; v.shift = sh;
    v.store = st; v.flush = fl; v.send = sb; v.block = bb; v.err = er;
    return v;
  endfunction

  initial begin
    vec_t v;
    vec_t e;
    int   m_fill, m_block, m_err, t, nf, c0, c1, lst;
    bit   exp_ready;

    i_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(3);

    // Directed table, applied back-to-back from reset
    tbl.push_back(mk(0, 0, 0,  2,  2,   0,   2,   0, 0, 0, 0,   4, 0));
    tbl.push_back(mk(1, 1, 0, 34, 34,   4,  38,   4, 0, 0, 0,  72, 0));
    tbl.push_back(mk(1, 1, 0, 34, 34,   0,  34,   0, 1, 0, 0, 140, 0));
    tbl.push_back(mk(3, 3, 0, 24, 24,  68,  92,  68, 0, 0, 0, 188, 0));
    tbl.push_back(mk(2, 2, 0,  6,  6, 116, 122, 116, 0, 1, 0, 200, 0));
    tbl.push_back(mk(4, 5, 0, 12, 16,   0,  12,   0, 0, 0, 0, 228, 0));
    tbl.push_back(mk(0, 0, 1,  2,  2,  28,  30,  28, 0, 1, 0, 232, 0));
    tbl.push_back(mk(1, 1, 0, 34, 34,   0,  34,   0, 0, 0, 0,  68, 0));
    for (int k = 2; k <= 7; k++)
      tbl.push_back(mk(1, 1, 0, 34, 34, 0, 34, 0, 1, 0, 0, 68 * k, 0));
    tbl.push_back(mk(1, 1, 1, 34, 34,   0,  34,   0, 1, 1, 1, 544, 0));
    tbl.push_back(mk(2, 2, 0,  6,  6,   0,   6,   0, 0, 0, 0,  12, 0));
    tbl.push_back(mk(6, 0, 0, 34,  2,  12,  46,  12, 0, 0, 0,  48, 1));
    tbl.push_back(mk(0, 0, 0,  2,  2,  48,  50,  48, 0, 0, 0,  52, 1));
    tbl.push_back(mk(7, 7, 1, 34, 34,  52,  86,  52, 0, 1, 0, 120, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      beat($sformatf("vec%0d", i), tbl[i].c0, tbl[i].c1, tbl[i].last);
      check_out($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset mid-block clears fill, block and the sticky error
    beat("pre_rst", 3'd1, 3'd1, 1'b0);
    check_out("pre_rst", mk(1, 1, 0, 34, 34, 0, 34, 0, 0, 0, 0, 68, 1));
    do_reset(1);
    beat("post_rst", 3'd0, 3'd0, 1'b0);
    check_out("post_rst", mk(0, 0, 0, 2, 2, 0, 2, 0, 0, 0, 0, 4, 0));

    // Backpressure: drain, accept one beat, then stall three cycles
    @(posedge clk);
    #1;
    chk("bp_drain", "valid", int'(o_valid), 0);
    i_ready = 1'b0;
    beat("bp_a", 3'd2, 3'd2, 1'b0);
    check_out("bp_a", mk(2, 2, 0, 6, 6, 4, 10, 4, 0, 0, 0, 16, 0));
    i_valid = 1'b1;
    i_code  = 6'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall", "ready", int'(o_ready), 0);
      check_out("bp_stall", mk(2, 2, 0, 6, 6, 4, 10, 4, 0, 0, 0, 16, 0));
      @(posedge clk);
      #1;
    end
    check_out("bp_hold", mk(2, 2, 0, 6, 6, 4, 10, 4, 0, 0, 0, 16, 0));
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_resume", "ready", int'(o_ready), 1);
      @(posedge clk);
      #1;
      check_out($sformatf("bp_resume%0d", i),
                mk(0, 0, 0, 2, 2, 16 + 4 * i, 18 + 4 * i, 16 + 4 * i, 0, 0, 0, 20 + 4 * i, 0));
    end
    i_valid = 1'b0;

    // Randomized traffic against a reference model
    do_reset(1);
    m_fill = 0; m_block = 0; m_err = 0;
    e.shift = 0;
    exp_ready = 1'b1;
    begin
      bit e_valid;
      e_valid = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        c0  = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        c1  = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        lst = ($urandom_range(0, 5) == 0) ? 1 : 0;
        i_valid = ($urandom_range(0, 3) != 0);
        i_ready = ($urandom_range(0, 3) != 0);
        i_code  = {3'(c1), 3'(c0)};
        i_last  = 1'(lst);
        #1;
        exp_ready = !e_valid || i_ready;
        chk("rand", "ready", int'(o_ready), int'(exp_ready));
        if (e_valid) check_out($sformatf("rand%0d", cyc), e);
        else chk("rand", "valid", int'(o_valid), 0);
        @(posedge clk);
        if (i_valid && exp_ready) begin
          e.len0 = mlen(c0);
          e.len1 = mlen(c1);
          t = e.len0 + e.len1;
          if (m_fill + t > 128) begin
            e.store = 1; e.shift = 0; nf = t;
          end else begin
            e.store = 0; e.shift = m_fill; nf = m_fill + t;
          end
          e.flush = (nf == 128 || lst != 0) ? 1 : 0;
          m_fill  = (e.flush != 0) ? 0 : nf;
          e.off0  = e.shift;
          e.off1  = e.shift + e.len0;
          e.block = m_block + t;
          e.send  = (lst != 0 && e.block > 512) ? 1 : 0;
          m_block = (lst != 0) ? 0 : e.block;
          if (c0 > 5 || c1 > 5) m_err = 1;
          e.err   = m_err;
          e_valid = 1'b1;
        end else if (i_ready) begin
          e_valid = 1'b0;
        end
        #1;
      end
    end
    i_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/length_pack_controller.md
# length_pack_controller

Parametrised N-lane successor to the two-word length generator in the compressor's Stage 2. Each accepted beat carries LANES per-word pattern codes. The block:
- computes each word's compressed length, the beat total and per-lane bit offsets;
- tracks fill level of the current output line and tells the packer where to place the beat and when to close a line;
- tracks total compressed size per cache block and raises a send-back when compression does not pay.

## Interface
Parameters:
- LANES, 2: words per beat.
- WORD_BITS, 32: uncompressed word width.
- IDX_W, 4: dictionary index width.
- CACHE_LINE, 128: output line width in bits. Must satisfy CACHE_LINE >= LANES*(WORD_BITS+2).
- WORDS_PER_BLOCK, 16: words per cache block. BLOCK_BITS = WORDS_PER_BLOCK*WORD_BITS.

Ports (LW = clog2(WORD_BITS+3), FW = clog2(CACHE_LINE+1), BW = clog2(WORDS_PER_BLOCK*(WORD_BITS+2)+1)):
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid && o_ready.
- i_code  in  3*LANES  per-lane pattern code; lane k in bits [3k+2:3k].
- i_last  in  1  beat is last of the cache block.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_lane_len  out  LW*LANES  per-lane compressed length.
- o_lane_off  out  FW*LANES  per-lane bit offset in the current line.
- o_shift_amount  out  FW  line offset where the beat starts.
- o_store_flag  out  1  close the current line before placing this beat.
- o_flush  out  1  close the line after placing this beat.
- o_send_back  out  1  block did not compress; send raw.
- o_block_bits  out  BW  block compressed bits including this beat.
- o_err  out  1  sticky illegal-code flag.

## Operation
Code-to-length map (defaults in parentheses):
- 0 ZZZZ: 2.
- 1 XXXX: 2+WORD_BITS (34).
- 2 MMMM: 2+IDX_W (6).
- 3 MMXX: 4+IDX_W+WORD_BITS/2 (24).
- 4 ZZZX: 4+WORD_BITS/4 (12).
- 5 MMMX: 4+IDX_W+WORD_BITS/4 (16).
- 6, 7: illegal. Length = XXXX length; o_err sets and holds until reset.

Beat total T = sum of lane lengths. Registered state: fill (FW bits, 0..CACHE_LINE), block (BW bits).

On acceptance:
- If fill+T > CACHE_LINE: store_flag=1, shift=0, new fill=T.
- Otherwise: store_flag=0, shift=fill, new fill=fill+T.
- If new fill == CACHE_LINE or i_last: flush=1 and next fill=0. Otherwise next fill = new fill.
- Lane offsets: off[0]=shift; off[k]=off[k-1]+len[k-1].
- block_bits = block+T.
- If i_last: send_back = (block_bits > BLOCK_BITS) and block clears to 0. Otherwise block = block_bits and send_back=0.

Exact fill and overflow never coincide; an empty line always fits one beat. Arithmetic is unsigned, sized to the maximum sum with no wrap.

## Timing
- One output register stage; latency 1 cycle from acceptance to o_valid.
- o_ready = i_reset && (!o_valid || i_ready). An accept and a drain in the same cycle give full throughput.
- While o_valid && !i_ready: all outputs hold and fill/block do not change.
- During reset, and on the first cycle after it, every output is 0 except o_ready, which is 1 from the first cycle after reset is released.
- Reset mid-block discards fill, block and o_err with no flags emitted.
- i_code and i_last are sampled only on acceptance.

## Structure
- Shared package: code enum (ZZZZ..MMMX), length function of (code, WORD_BITS, IDX_W), width helper functions.
- One sub-module: word_length_decoder, a combinational per-lane code-to-length decoder with an illegal flag, instantiated LANES times via generate.
- Prefix-sum offsets, fill/block accumulators and the handshake register live in the top module.

## Test plan
All scenarios use default parameters.
- From reset, beat {ZZZZ,ZZZZ}: len 2,2; shift 0; off 0,2; no flags; block_bits 4. Next beat {XXXX,XXXX}: shift 4; off 4,38; block_bits 72.
- Overflow: fill 72, beat {XXXX,XXXX} (68): store_flag=1, shift 0, off 0,34; next fill 68.
- Exact fill: beats {XXXX,XXXX}, {MMXX,MMXX}, {MMMM,MMMM}. Third beat: shift 116, flush=1, store_flag=0. Following beat gets shift 0.
- Send-back: 8 beats {XXXX,XXXX}, i_last on the 8th: o_block_bits 544, o_send_back=1, o_flush=1. Next beat: block_bits equals its own T.
- Backpressure: i_ready low for 3 cycles with i_valid high: o_ready low, outputs stable, fill unchanged. Beats then resume back-to-back, one per cycle.
- Lane code 6: lane len 34, o_err=1 and stays 1. Reset low for one cycle mid-block: o_err, fill and block clear; next beat gets shift 0.
